// File: rtl/conv_pkg.sv
// Shared types and sizing for the convolution datapath.
package conv_pkg;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned IMAGE_MAX_W = 64;
    localparam int unsigned ADDR_W      = $clog2(IMAGE_MAX_W);

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [ADDR_W-1:0] col_t;
    typedef logic [2:0]        row_t;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StErr
    } seq_state_t;

    // One slot of the window alignment pipe.
    typedef struct packed {
        logic   vld;
        logic   sof;
        logic   eol;
        pixel_t pix;
    } seq_dly_t;

endpackage

// File: rtl/conv_seq_dly.sv
// Fixed-depth alignment pipe that matches the window stream to the line-buffer read latency.
module conv_seq_dly
    import conv_pkg::*;
#(
    parameter int unsigned LB_LAT = 2
) (
    input  logic     clk,
    input  logic     arst_n,
    input  seq_dly_t dly_i,
    output seq_dly_t dly_o
);

    seq_dly_t r_pipe [LB_LAT];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < int'(LB_LAT); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= dly_i;
            for (int i = 1; i < int'(LB_LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign dly_o = r_pipe[LB_LAT-1];

endmodule

// File: rtl/conv_cntrl_seq.sv
// Line-buffer sequencer: drives push/pop/data to the line buffers, learns frame width,
// flags line-length errors and emits a latency-matched window-valid stream.
module conv_cntrl_seq
    import conv_pkg::*;
#(
    parameter int unsigned LB_LAT = 2,
    parameter int unsigned ROWS_N = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              pix_vld_i,
    input  pixel_t            pix_dat_i,
    input  logic              pix_sof_i,
    input  logic              pix_eol_i,
    output logic [ROWS_N:1]   lb_push_o,
    output logic [ROWS_N:1]   lb_pop_o,
    output pixel_t            lb_dat_o,
    output logic              lb_sof_o,
    output logic              lb_eol_o,
    output logic              win_vld_o,
    output pixel_t            win_dat_o,
    output logic              win_sof_o,
    output logic              win_eol_o,
    output logic              err_o
);

    localparam col_t COL_LAST = col_t'(IMAGE_MAX_W - 1);
    localparam row_t ROW_FULL = row_t'(ROWS_N);
    localparam row_t ROW_LAST = row_t'(ROWS_N - 1);

    seq_state_t r_state, w_state_nxt;
    col_t       r_col,   w_col_nxt;
    row_t       r_row,   w_row_nxt;
    col_t       r_width, w_width_nxt;
    logic       r_err,   w_err_nxt;

    logic       w_accept;
    logic       w_bad;
    logic       w_push;
    col_t       w_col_cur;
    row_t       w_row_cur;
    seq_dly_t   w_dly_in;
    seq_dly_t   w_dly_out;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= StIdle;
            r_col   <= '0;
            r_row   <= '0;
            r_width <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_width <= w_width_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_width_nxt = r_width;
        w_err_nxt   = r_err;

        // A sof pixel is processed as column 0 of row 0 of a fresh frame.
        w_col_cur = pix_sof_i ? '0 : r_col;
        w_row_cur = pix_sof_i ? '0 : r_row;
        w_accept  = pix_vld_i && (pix_sof_i || r_state == StFill || r_state == StRun);

        w_bad = 1'b0;
        if (w_row_cur != '0) begin
            if (pix_eol_i && (w_col_cur != r_width)) begin
                w_bad = 1'b1;
            end
            if (!pix_eol_i && (w_col_cur == r_width)) begin
                w_bad = 1'b1;
            end
        end
        if (!pix_eol_i && (w_col_cur == COL_LAST)) begin
            w_bad = 1'b1;
        end
        w_push = w_accept && !w_bad;

        if (w_accept) begin
            if (pix_sof_i) begin
                w_state_nxt = StFill;
                w_col_nxt   = '0;
                w_row_nxt   = '0;
                w_width_nxt = '0;
                w_err_nxt   = 1'b0;
            end
            if (w_bad) begin
                w_state_nxt = StErr;
                w_err_nxt   = 1'b1;
            end else if (pix_eol_i) begin
                w_col_nxt = '0;
                if (w_row_cur == '0) begin
                    w_width_nxt = w_col_cur;
                end
                if (w_row_cur < ROW_FULL) begin
                    w_row_nxt = w_row_cur + 3'd1;
                end
                if (w_row_cur == ROW_LAST) begin
                    w_state_nxt = StRun;
                end
            end else begin
                w_col_nxt = w_col_cur + col_t'(1);
            end
        end
    end

    always_comb begin
        lb_push_o = {ROWS_N{w_push}};
        lb_pop_o  = '0;
        for (int i = 1; i <= int'(ROWS_N); i++) begin
            lb_pop_o[i] = w_push && (w_row_cur >= row_t'(i));
        end
        lb_dat_o = w_push ? pix_dat_i : '0;
        lb_sof_o = w_push && pix_sof_i;
        lb_eol_o = w_push && pix_eol_i;

        // Only pixels entering a full window are carried down the pipe.
        w_dly_in = '0;
        if (w_push && (w_row_cur == ROW_FULL)) begin
            w_dly_in.vld = 1'b1;
            w_dly_in.sof = pix_sof_i;
            w_dly_in.eol = pix_eol_i;
            w_dly_in.pix = pix_dat_i;
        end
    end

    conv_seq_dly #(
        .LB_LAT (LB_LAT)
    ) u_dly (
        .clk    (clk),
        .arst_n (arst_n),
        .dly_i  (w_dly_in),
        .dly_o  (w_dly_out)
    );

    assign win_vld_o = w_dly_out.vld;
    assign win_sof_o = w_dly_out.sof;
    assign win_eol_o = w_dly_out.eol;
    assign win_dat_o = w_dly_out.pix;
    assign err_o     = r_err;

endmodule

// File: tb/tb_conv_cntrl_seq.sv
// Directed, table-driven bench for the line-buffer sequencer.
module tb_conv_cntrl_seq;
    import conv_pkg::*;

    localparam int unsigned LB_LAT = 2;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       pix_vld_i = 1'b0;
    pixel_t     pix_dat_i = '0;
    logic       pix_sof_i = 1'b0;
    logic       pix_eol_i = 1'b0;
    logic [4:1] lb_push_o;
    logic [4:1] lb_pop_o;
    pixel_t     lb_dat_o;
    logic       lb_sof_o;
    logic       lb_eol_o;
    logic       win_vld_o;
    pixel_t     win_dat_o;
    logic       win_sof_o;
    logic       win_eol_o;
    logic       err_o;

    always #5 clk = ~clk;

    conv_cntrl_seq #(
        .LB_LAT (LB_LAT),
        .ROWS_N (4)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .pix_vld_i (pix_vld_i),
        .pix_dat_i (pix_dat_i),
        .pix_sof_i (pix_sof_i),
        .pix_eol_i (pix_eol_i),
        .lb_push_o (lb_push_o),
        .lb_pop_o  (lb_pop_o),
        .lb_dat_o  (lb_dat_o),
        .lb_sof_o  (lb_sof_o),
        .lb_eol_o  (lb_eol_o),
        .win_vld_o (win_vld_o),
        .win_dat_o (win_dat_o),
        .win_sof_o (win_sof_o),
        .win_eol_o (win_eol_o),
        .err_o     (err_o)
    );

    // One cycle of stimulus plus expectations; win marks a pixel that must reappear on
    // the window stream LB_LAT cycles later, err is err_o as seen during this cycle.
    typedef struct {
        logic       vld;
        logic       sof;
        logic       eol;
        pixel_t     dat;
        logic       push;
        logic [3:0] pop;
        logic       err;
        logic       win;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [3:0] pops(input int row);
        case (row)
            0:       return 4'b0000;
            1:       return 4'b0001;
            2:       return 4'b0011;
            3:       return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic vld, input logic sof, input logic eol, input int dat,
                       input logic push, input logic [3:0] pop, input logic err,
                       input logic win);
        vec_t v;
        v.vld  = vld;
        v.sof  = sof;
        v.eol  = eol;
        v.dat  = pixel_t'(dat);
        v.push = push;
        v.pop  = pop;
        v.err  = err;
        v.win  = win;
        tbl.push_back(v);
    endtask

    task automatic idle(input int n, input logic err);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 0, 1'b0, 4'b0000, err, 1'b0);
    endtask

    task automatic do_reset();
        arst_n    = 1'b0;
        pix_vld_i = 1'b0;
        pix_sof_i = 1'b0;
        pix_eol_i = 1'b0;
        pix_dat_i = '0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    // Applies the table starting right after reset; leaves time at posedge+1.
    task automatic run_table(input string name);
        logic       exp_wv;
        logic [3:0] exp_push;
        int         j;
        for (int k = 0; k < tbl.size(); k++) begin
            pix_vld_i = tbl[k].vld;
            pix_sof_i = tbl[k].sof;
            pix_eol_i = tbl[k].eol;
            pix_dat_i = tbl[k].dat;
            @(negedge clk);
            j        = k - int'(LB_LAT);
            exp_wv   = (j >= 0) ? tbl[j].win : 1'b0;
            exp_push = tbl[k].push ? 4'b1111 : 4'b0000;
            check({name, "_ctl"}, k, {22'd0, lb_push_o, lb_pop_o, err_o, win_vld_o},
                  {22'd0, exp_push, tbl[k].pop, tbl[k].err, exp_wv});
            if (tbl[k].push || !tbl[k].vld) begin
                check({name, "_lbdat"}, k, {22'd0, lb_dat_o, lb_sof_o, lb_eol_o},
                      tbl[k].push ? {22'd0, tbl[k].dat, tbl[k].sof, tbl[k].eol} : 32'd0);
            end
            if (exp_wv) begin
                check({name, "_windat"}, k, {22'd0, win_dat_o, win_sof_o, win_eol_o},
                      {22'd0, tbl[j].dat, tbl[j].sof, tbl[j].eol});
            end
            @(posedge clk);
            #1;
        end
        pix_vld_i = 1'b0;
        pix_sof_i = 1'b0;
        pix_eol_i = 1'b0;
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Pixels before any sof are dropped.
        do_reset();
        idle(1, 1'b0);
        add(1, 0, 0, 'h11, 0, 4'b0000, 0, 0);
        add(1, 0, 1, 'h12, 0, 4'b0000, 0, 0);
        add(1, 0, 0, 'h13, 0, 4'b0000, 0, 0);
        idle(3, 1'b0);
        run_table("presof");

        // Six lines of width 8: fill, then window stream from line 5.
        do_reset();
        idle(1, 1'b0);
        for (int l = 0; l < 6; l++)
            for (int c = 0; c < 8; c++)
                add(1, (l == 0 && c == 0), (c == 7), l * 16 + c, 1, pops(l), 0, (l >= 4));
        idle(3, 1'b0);
        run_table("w8");

        // Short third line: error, drop until sof, sof clears err.
        do_reset();
        idle(1, 1'b0);
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 8; c++)
                add(1, (l == 0 && c == 0), (c == 7), 'h40 + l * 8 + c, 1, pops(l), 0, 0);
        for (int c = 0; c < 6; c++) add(1, 0, 0, 'h60 + c, 1, 4'b0011, 0, 0);
        add(1, 0, 1, 'h66, 0, 4'b0000, 0, 0);
        add(1, 0, 0, 'h67, 0, 4'b0000, 1, 0);
        add(1, 0, 1, 'h68, 0, 4'b0000, 1, 0);
        add(1, 0, 0, 'h69, 0, 4'b0000, 1, 0);
        add(1, 1, 0, 'h70, 1, 4'b0000, 1, 0);
        add(1, 0, 0, 'h71, 1, 4'b0000, 0, 0);
        add(1, 0, 1, 'h72, 1, 4'b0000, 0, 0);
        idle(2, 1'b0);
        run_table("shorteol");

        // Missing eol at the learned width is an error too.
        do_reset();
        idle(1, 1'b0);
        for (int c = 0; c < 4; c++) add(1, (c == 0), (c == 3), 'h80 + c, 1, 4'b0000, 0, 0);
        for (int c = 0; c < 3; c++) add(1, 0, 0, 'h90 + c, 1, 4'b0001, 0, 0);
        add(1, 0, 0, 'h93, 0, 4'b0000, 0, 0);
        idle(2, 1'b1);
        run_table("noeol");

        // sof in RUN mid-line: in-flight window entries drain, width relearned.
        do_reset();
        idle(1, 1'b0);
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 4; c++)
                add(1, (l == 0 && c == 0), (c == 3), 'hA0 + l * 4 + c, 1, pops(l), 0, 0);
        for (int c = 0; c < 3; c++) add(1, 0, 0, 'hC0 + c, 1, 4'b1111, 0, 1);
        add(1, 1, 0, 'hD0, 1, 4'b0000, 0, 0);
        add(1, 0, 1, 'hD1, 1, 4'b0000, 0, 0);
        add(1, 0, 0, 'hD2, 1, 4'b0001, 0, 0);
        add(1, 0, 1, 'hD3, 1, 4'b0001, 0, 0);
        idle(3, 1'b0);
        run_table("abort");

        // IMAGE_MAX_W pixels without eol: the last one overflows.
        do_reset();
        idle(1, 1'b0);
        for (int c = 0; c < int'(IMAGE_MAX_W) - 1; c++)
            add(1, (c == 0), 0, c, 1, 4'b0000, 0, 0);
        add(1, 0, 0, 'hEE, 0, 4'b0000, 0, 0);
        idle(1, 1'b1);
        add(1, 0, 1, 'hEF, 0, 4'b0000, 1, 0);
        idle(1, 1'b1);
        run_table("ovf");

        // Frame of single-pixel lines.
        do_reset();
        idle(1, 1'b0);
        for (int l = 0; l < 8; l++) add(1, (l == 0), 1, 'h30 + l, 1, pops(l), 0, (l >= 4));
        idle(3, 1'b0);
        run_table("w1");

        // Async reset with window entries in flight.
        do_reset();
        for (int l = 0; l < 5; l++)
            for (int c = 0; c < 2; c++)
                add(1, (l == 0 && c == 0), (c == 1), 'h50 + l * 2 + c, 1, pops(l), 0, (l >= 4));
        run_table("prerst");
        check("rst_inflight", 0, {31'd0, win_vld_o}, 32'd1);
        arst_n = 1'b0;
        #1;
        check("rst_clear", 0, {22'd0, win_vld_o, err_o, lb_push_o, lb_pop_o},
              32'd0);
        @(posedge clk);
        #1 arst_n = 1'b1;
        pix_vld_i = 1'b1;
        pix_dat_i = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_after", i, {22'd0, win_vld_o, err_o, lb_push_o, lb_pop_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        pix_vld_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_cntrl_seq.md
# conv_cntrl_seq

Line-buffer sequencer sitting directly upstream of `conv_cntrl_lb_fpga` in the convolution datapath. It accepts the raw pixel stream and drives the four line buffers: per-buffer push/pop strobes, the shared write data, and `sof`/`eol`. It tracks column and row position and learns the frame width from the first line. It emits a window-valid stream, delay-matched to the line-buffer read latency, so the downstream kernel sees the current pixel aligned with `colD_o[4:1]`.

## Interface
Parameters:
- `LB_LAT`, 2, line-buffer read latency in cycles (BRAM read + output flop); depth of the alignment pipe.
- `ROWS_N`, 4, number of line buffers (fixed at 4 in this revision).

Ports:
- `clk`  in  1  clock.
- `arst_n`  in  1  reset; asynchronous, active-low.
- `pix_vld_i`  in  1  input pixel valid (no backpressure).
- `pix_dat_i`  in  `conv_pkg::pixel_t`  input pixel.
- `pix_sof_i`  in  1  first pixel of frame.
- `pix_eol_i`  in  1  last pixel of line.
- `lb_push_o`  out  [4:1]  per-buffer write strobe.
- `lb_pop_o`  out  [4:1]  per-buffer read enable.
- `lb_dat_o`  out  `conv_pkg::pixel_t`  write data to all buffers.
- `lb_sof_o`, `lb_eol_o`  out  1  frame/line markers to the buffers.
- `win_vld_o`  out  1  window column valid, aligned with `colD_o`.
- `win_dat_o`  out  `conv_pkg::pixel_t`  current-row pixel, delayed by `LB_LAT`.
- `win_sof_o`, `win_eol_o`  out  1  delayed markers for the window stream.
- `err_o`  out  1  sticky line-length error; cleared on the next accepted `sof`.

## Operation
- States: IDLE, FILL, RUN, ERR. Reset state is IDLE.
- Any valid pixel with `pix_sof_i` set, in any state, restarts the frame:
  - `col` = 0, `row` = 0, `err_o` cleared.
  - Width is relearned.
  - The pixel is forwarded.
  - Next state is FILL.
- IDLE:
  - Non-sof pixels are dropped.
  - No push or pop is issued.
- FILL and RUN, for each accepted pixel:
  - `lb_push_o` = 4'b1111.
  - `lb_pop_o[i]` = 1 iff `row >= i`.
  - `lb_dat_o`, `lb_sof_o`, `lb_eol_o` are combinational pass-through of the inputs, gated by `pix_vld_i`.
- Column counter:
  - `col` increments per accepted pixel.
  - On `eol`, `col` resets to 0 and `row` increments, saturating at 4.
- Width learning:
  - First line of the frame: `width` latched as `col` at `eol`.
  - Later lines: an `eol` with `col != width`, or `col == width` without `eol`, is an error.
- Overflow: `col` reaching `IMAGE_MAX_W-1` without `eol` is an error.
- FILL→RUN on the `eol` that takes `row` to 4.
- Error handling:
  - An error sets `err_o` and moves to ERR.
  - The offending pixel is not pushed.
  - ERR drops all pixels until `sof`.
- Window stream:
  - `win_vld_o` = accepted pixel with `row == 4` (RUN), delayed by `LB_LAT`.
  - `win_dat_o`, `win_sof_o`, `win_eol_o` are delayed identically.

## Timing
- Reset values: all outputs 0; `col`, `row`, `width` = 0; state IDLE; delay pipe cleared.
- Latency:
  - `lb_*` outputs: 0 cycles (combinational from the inputs and registered state).
  - `win_*` outputs: exactly `LB_LAT` cycles after the accepted pixel.
- A single-pixel line (`sof` and `eol` in the same cycle) is legal: `width` = 0, `row` becomes 1.
- `sof` during RUN aborts the frame mid-line:
  - In-flight `win_*` entries still drain.
  - Rows are refilled from 0.
- Asserting `arst_n` low mid-operation clears everything immediately; no partial outputs after release.
- `err_o` rises the cycle after the offending pixel.

## Structure
- Add to `conv_pkg`:
  - `ADDR_W` = `$clog2(IMAGE_MAX_W)`.
  - `col_t`.
  - `row_t` (3 bits).
  - `seq_state_t` enum.
- Sub-module `conv_seq_dly`: an `LB_LAT`-deep shift register carrying {vld, sof, eol, pixel}, with vld reset to 0.
- Sequencing logic and FSM live in `conv_cntrl_seq`.

## Test plan
- Reset, then 6 lines of width 8 starting with `sof`:
  - Pops are 0000, 0001, 0011, 0111, 1111, 1111 per line.
  - First `win_vld_o` appears on line 5, col 0, 2 cycles after input.
- Line 3 ends at col 6 while width is 8:
  - `err_o` = 1 the next cycle; no push for that pixel.
  - Later pixels dropped until `sof`; `sof` clears `err_o`.
- `sof` mid-line during RUN: `row` resets to 0, pops return to 0000, and the 2 in-flight `win_vld_o` entries drain.
- Pixels before any `sof` after reset: no push, no `win_vld_o`.
- Line of `IMAGE_MAX_W` pixels without `eol`: error on the overflow pixel.
- Frame of 1-pixel lines (`sof` and `eol` on the first pixel, `eol` on each following pixel): `row` saturates at 4, and `win_vld_o` fires every pixel from line 5 onward.
